// File: rtl/inst_loader.sv
// Program loader: unpacks a framed byte stream into 32-bit words for instruction RAM.
// Keeps the CPU halted until a frame with a matching XOR checksum has been written.
`timescale 1ns/1ps
module inst_loader #(
  parameter int ADDR          = 6,
  parameter int SIZE          = 32,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            load_err
);
  localparam int CW   = ADDR + 1;
  localparam int NMAX = (ADDR >= 8) ? 255 : (1 << ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_WRITE,
    S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_word_cnt;
  logic [CW-1:0]   r_n;
  logic [1:0]      r_byte_cnt;
  logic [SIZE-1:0] r_word;
  logic [7:0]      r_csum;
  logic            r_hold;
  logic            r_done;
  logic            r_err;
  logic            w_fire;
  logic            w_hdr;
  logic            w_n_ok;
  logic            w_last;

  assign rx_ready  = !reset && (r_state != S_WRITE);
  assign w_fire    = rx_valid && rx_ready;
  assign w_hdr     = w_fire && (rx_data == 8'hA5);
  assign w_n_ok    = (rx_data != 8'd0) &&
                     ({24'd0, rx_data} <= 32'(NMAX));
  assign w_last    = (r_word_cnt == r_n - CW'(1));

  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_word_cnt[ADDR-1:0];
  assign mem_wdata = r_word;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_hdr) w_next = S_COUNT;
      end
      S_COUNT: begin
        if (w_fire) w_next = w_n_ok ? S_DATA : S_ERR;
      end
      S_DATA: begin
        if (w_fire && r_byte_cnt == 2'd3)
          w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (w_fire)
          w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_n        <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_csum     <= '0;
      r_hold     <= HOLD_AT_RESET;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_hdr) begin
            r_hold <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        S_COUNT: begin
          if (w_fire) begin
            if (w_n_ok) begin
              r_n        <= CW'(rx_data);
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
              r_csum     <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_word     <= {r_word[SIZE-9:0], rx_data};
            r_csum     <= r_csum ^ rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_word_cnt <= r_word_cnt + CW'(1);
        end
        S_CHECK: begin
          if (w_fire) begin
            if (rx_data == r_csum) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: framing, checksum, count limits,
// rx_ready backpressure, payload 0xA5 and mid-frame reset.
`timescale 1ns/1ps
module tb_inst_loader;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  inst_loader #(.ADDR(6), .SIZE(32), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .reset(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_n = 0;
  int rdy_low = 0;
  logic        prev_we = 1'b0;
  logic [5:0]  wr_addr [0:255];
  logic [31:0] wr_data [0:255];

  // write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (prev_we !== 1'b0 || rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL we_pulse: prev_we=%b rx_ready=%b, required 0/0",
                 prev_we, rx_ready);
      end
      if (wr_n < 256) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
      end
      wr_n++;
    end
    if (!rst && rx_ready === 1'b0) rdy_low++;
    prev_we = mem_we;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // called at a negedge; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 20 && rx_ready !== 1'b1; k++) @(negedge clk);
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_wait: rx_ready=%b, required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t s, input int maxgap);
    foreach (s[i]) send_byte(s[i], maxgap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err}
        !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b, required 0 0 00 0 1 0 0",
               rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: rx_ready=%b, required 1", rx_ready);
    end
  endtask

  task automatic test_single_word();
    bq_t s;
    int base;
    base = wr_n;
    s = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_seq(s, 0);
    checks++;
    if (wr_n !== base + 1) begin
      errors++;
      $display("FAIL single_wr_count: got %0d, required %0d", wr_n - base, 1);
    end else begin
      checks++;
      if (wr_addr[base] !== 6'd0 || wr_data[base] !== 32'h12345678) begin
        errors++;
        $display("FAIL single_wr: addr=%h data=%h, required 00 12345678",
                 wr_addr[base], wr_data[base]);
      end
    end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL single_status: done/err/hold=%b%b%b, required 100",
               load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_back_to_back();
    bq_t s;
    int base;
    int low0;
    base = wr_n;
    low0 = rdy_low;
    s = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
          8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    send_seq(s, 0);
    checks++;
    if (wr_n !== base + 2) begin
      errors++;
      $display("FAIL two_wr_count: got %0d, required 2", wr_n - base);
    end else begin
      checks++;
      if (wr_addr[base] !== 6'd0 || wr_data[base] !== 32'h1 ||
          wr_addr[base+1] !== 6'd1 || wr_data[base+1] !== 32'h2) begin
        errors++;
        $display("FAIL two_wr: %h=%h %h=%h, required 00=00000001 01=00000002",
                 wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
      end
    end
    checks++;
    if (rdy_low - low0 !== 2) begin
      errors++;
      $display("FAIL two_rdy_low: got %0d cycles, required 2", rdy_low - low0);
    end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL two_status: done/err/hold=%b%b%b, required 100",
               load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_bad_checksum();
    bq_t s;
    int base;
    base = wr_n;
    s = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_seq(s, 0);
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame: hold=%b done=%b, required 1 0", cpu_hold, load_done);
    end
    send_byte(8'h00, 0);
    checks++;
    if (wr_n !== base + 1 || wr_data[base] !== 32'h12345678) begin
      errors++;
      $display("FAIL badck_wr: count=%0d data=%h, required 1 12345678",
               wr_n - base, wr_data[base]);
    end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b011) begin
      errors++;
      $display("FAIL badck_status: done/err/hold=%b%b%b, required 011",
               load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_bad_count();
    int base;
    base = wr_n;
    send_byte(8'hA5, 0);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL hdr_clears_err: err=%b, required 0", load_err);
    end
    send_byte(8'h00, 0);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL n_zero: err=%b hold=%b, required 1 1", load_err, cpu_hold);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h41, 0);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL n_65: err=%b hold=%b, required 1 1", load_err, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n !== base) begin
      errors++;
      $display("FAIL bad_n_writes: got %0d, required 0", wr_n - base);
    end
  endtask

  task automatic test_garbage_payload();
    bq_t s;
    int base;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = wr_n;
    s = '{8'h00, 8'hFF, 8'h5A};
    send_seq(s, 0);
    checks++;
    if ({rx_ready, load_done, load_err, cpu_hold} !== 4'b1001) begin
      errors++;
      $display("FAIL garbage: rdy/done/err/hold=%b%b%b%b, required 1001",
               rx_ready, load_done, load_err, cpu_hold);
    end
    s = '{8'hA5, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4};
    send_seq(s, 0);
    checks++;
    if (wr_n !== base + 1 || wr_addr[base] !== 6'd0 ||
        wr_data[base] !== 32'hA5000001) begin
      errors++;
      $display("FAIL payload_a5: count=%0d data=%h, required 1 a5000001",
               wr_n - base, wr_data[base]);
    end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL payload_status: done/err/hold=%b%b%b, required 100",
               load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_max_frame();
    bq_t s;
    int base;
    logic [7:0] ck;
    logic [7:0] b;
    logic [31:0] w;
    base = wr_n;
    ck = 8'h00;
    s = '{8'hA5, 8'h40};
    for (int i = 0; i < 256; i++) begin
      b = 8'(i * 7 + 3);
      s.push_back(b);
      ck = ck ^ b;
    end
    s.push_back(ck);
    send_seq(s, 0);
    checks++;
    if (wr_n !== base + 64) begin
      errors++;
      $display("FAIL max_count: got %0d, required 64", wr_n - base);
    end else begin
      for (int i = 0; i < 64; i++) begin
        w = {8'(i*28 + 3), 8'(i*28 + 10), 8'(i*28 + 17), 8'(i*28 + 24)};
        checks++;
        if (wr_addr[base+i] !== 6'(i) || wr_data[base+i] !== w) begin
          errors++;
          $display("FAIL max_word%0d: addr=%h data=%h, required %h %h",
                   i, wr_addr[base+i], wr_data[base+i], 6'(i), w);
        end
      end
    end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL max_status: done/err/hold=%b%b%b, required 100",
               load_done, load_err, cpu_hold);
    end
  endtask

  task automatic test_gaps_reset();
    bq_t s;
    int base;
    base = wr_n;
    s = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_seq(s, 3);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, cpu_hold, load_done, load_err} !== 5'b00100) begin
      errors++;
      $display("FAIL mid_reset: rdy/we/hold/done/err=%b%b%b%b%b, required 00100",
               rx_ready, mem_we, cpu_hold, load_done, load_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_n !== base + 1 || wr_data[base] !== 32'h11223344) begin
      errors++;
      $display("FAIL reset_partial: count=%0d data=%h, required 1 11223344",
               wr_n - base, wr_data[base]);
    end
    base = wr_n;
    s = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_seq(s, 3);
    checks++;
    if (wr_n !== base + 1 || wr_addr[base] !== 6'd0 ||
        wr_data[base] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fresh_wr: count=%0d data=%h, required 1 deadbeef",
               wr_n - base, wr_data[base]);
    end
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL fresh_status: done/err/hold=%b%b%b, required 100",
               load_done, load_err, cpu_hold);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_checksum();
    test_bad_count();
    test_garbage_payload();
    test_max_frame();
    test_gaps_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
